micro_sequencer: RTL and testbench

//  Upstream neighbour of control_unit. Fetches the instruction word, latches opcode/operands, and

---
 rtl/micro_sequencer_if.sv | 27 ++
 rtl/micro_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_micro_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
// Bus between the micro-sequencer and its environment: fetch/branch inputs,
// microstate address and status outputs.
interface micro_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic             hit;
    logic             z_flag;
    logic [15:0]      ins_in;
    logic [8:0]       addr_ins;
    logic [3:0]       operand1;
    logic [3:0]       operand2;
    logic             halted;
    logic             illegal_op;
    logic             mem_timeout;
    logic [CNT_W-1:0] ins_count;

    modport master (
        output en, hit, z_flag, ins_in,
        input  addr_ins, operand1, operand2, halted, illegal_op, mem_timeout, ins_count
    );

    modport slave (
        input  en, hit, z_flag, ins_in,
        output addr_ins, operand1, operand2, halted, illegal_op, mem_timeout, ins_count
    );
endinterface

// File: rtl/micro_sequencer.sv
// Walks the 9-bit microstate {alt, opcode, step} feeding control_unit: fetch,
// decode, per-opcode micro-steps, memory-hit waits with timeout retry, GOTOZ and HALT.
module micro_sequencer #(
    parameter int unsigned FETCH_TIMEOUT = 255,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    micro_sequencer_if.slave  bus
);
    localparam int unsigned WAIT_W = $clog2(FETCH_TIMEOUT + 1);

    localparam logic [4:0] OP_LOAD  = 5'b11100;
    localparam logic [4:0] OP_GOTOZ = 5'b10110;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    localparam logic [8:0] A_FETCH1    = 9'h000;
    localparam logic [8:0] A_INCPC     = 9'h001;
    localparam logic [8:0] A_LOAD0     = 9'h0E0;
    localparam logic [8:0] A_LOAD_WAIT = 9'h0E6;
    localparam logic [8:0] A_LOAD_HIT  = 9'h1E6;
    localparam logic [8:0] A_LOAD2     = 9'h0E2;
    localparam logic [8:0] A_LOAD3     = 9'h0E3;
    localparam logic [8:0] A_GOTOZ1    = 9'h0B0;
    localparam logic [8:0] A_GOTOZ_Z   = 9'h0B1;
    localparam logic [8:0] A_GOTOZ_NZ  = 9'h1B1;
    localparam logic [8:0] A_HALT      = 9'h0FF;

    typedef enum logic [3:0] {
        S_FETCH1, S_INCPC, S_LINEAR, S_LOAD0, S_LOAD_WAIT, S_LOAD_HIT,
        S_LOAD2, S_LOAD3, S_GOTOZ1, S_GOTOZ2, S_HALT
    } state_t;

    // Number of linear micro-steps per opcode; 0 marks opcodes without a linear sequence.
    function automatic logic [2:0] seq_len(input logic [4:0] op);
        case (op)
            5'b11010, 5'b01010, 5'b11001, 5'b01011, 5'b00011,
            5'b00101, 5'b00100, 5'b10100, 5'b10101: seq_len = 3'd2;
            5'b11011, 5'b11101:                     seq_len = 3'd3;
            5'b10001, 5'b10010:                     seq_len = 3'd4;
            5'b01101:                               seq_len = 3'd1;
            default:                                seq_len = 3'd0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [8:0]        addr_ins_q, addr_ins_d;
    logic [4:0]        opcode_q, opcode_d;
    logic [3:0]        operand1_q, operand1_d;
    logic [3:0]        operand2_q, operand2_d;
    logic              halted_q, halted_d;
    logic              illegal_op_q, illegal_op_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  ins_count_q, ins_count_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              wait_expired;
    logic              unused_ins_hi;

    assign unused_ins_hi = ^bus.ins_in[15:13];
    assign wait_expired  = (wait_q == WAIT_W'(FETCH_TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        addr_ins_d    = addr_ins_q;
        opcode_d      = opcode_q;
        operand1_d    = operand1_q;
        operand2_d    = operand2_q;
        halted_d      = halted_q;
        illegal_op_d  = illegal_op_q;
        mem_timeout_d = mem_timeout_q;
        ins_count_d   = ins_count_q;
        wait_d        = wait_q;

        // HALT is terminal until reset, regardless of en.
        if (bus.en && state_q != S_HALT) begin
            mem_timeout_d = 1'b0;
            wait_d        = '0;
            case (state_q)
                S_FETCH1, S_LOAD_WAIT: begin
                    if (bus.hit) begin
                        if (state_q == S_FETCH1) begin
                            opcode_d   = bus.ins_in[12:8];
                            operand1_d = bus.ins_in[7:4];
                            operand2_d = bus.ins_in[3:0];
                            state_d    = S_INCPC;
                            addr_ins_d = A_INCPC;
                        end else begin
                            state_d    = S_LOAD_HIT;
                            addr_ins_d = A_LOAD_HIT;
                        end
                    end else if (wait_expired) begin
                        mem_timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                S_INCPC: begin
                    ins_count_d = ins_count_q + CNT_W'(1);
                    if (opcode_q == OP_LOAD) begin
                        state_d    = S_LOAD0;
                        addr_ins_d = A_LOAD0;
                    end else if (opcode_q == OP_GOTOZ) begin
                        state_d    = S_GOTOZ1;
                        addr_ins_d = A_GOTOZ1;
                    end else if (opcode_q == OP_HALT) begin
                        state_d    = S_HALT;
                        addr_ins_d = A_HALT;
                        halted_d   = 1'b1;
                    end else if (seq_len(opcode_q) != 3'd0) begin
                        state_d    = S_LINEAR;
                        addr_ins_d = {1'b0, opcode_q, 3'b000};
                    end else begin
                        illegal_op_d = 1'b1;
                        state_d      = S_FETCH1;
                        addr_ins_d   = A_FETCH1;
                    end
                end
                S_LINEAR: begin
                    if (addr_ins_q[2:0] == seq_len(opcode_q) - 3'd1) begin
                        state_d    = S_FETCH1;
                        addr_ins_d = A_FETCH1;
                    end else begin
                        addr_ins_d = addr_ins_q + 9'd1;
                    end
                end
                S_LOAD0: begin
                    state_d    = S_LOAD_WAIT;
                    addr_ins_d = A_LOAD_WAIT;
                end
                S_LOAD_HIT: begin
                    state_d    = S_LOAD2;
                    addr_ins_d = A_LOAD2;
                end
                S_LOAD2: begin
                    state_d    = S_LOAD3;
                    addr_ins_d = A_LOAD3;
                end
                S_GOTOZ1: begin
                    state_d    = S_GOTOZ2;
                    addr_ins_d = bus.z_flag ? A_GOTOZ_Z : A_GOTOZ_NZ;
                end
                default: begin
                    state_d    = S_FETCH1;
                    addr_ins_d = A_FETCH1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH1;
            addr_ins_q    <= A_FETCH1;
            opcode_q      <= '0;
            operand1_q    <= '0;
            operand2_q    <= '0;
            halted_q      <= 1'b0;
            illegal_op_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
            ins_count_q   <= '0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            addr_ins_q    <= addr_ins_d;
            opcode_q      <= opcode_d;
            operand1_q    <= operand1_d;
            operand2_q    <= operand2_d;
            halted_q      <= halted_d;
            illegal_op_q  <= illegal_op_d;
            mem_timeout_q <= mem_timeout_d;
            ins_count_q   <= ins_count_d;
            wait_q        <= wait_d;
        end
    end

    assign bus.addr_ins    = addr_ins_q;
    assign bus.operand1    = operand1_q;
    assign bus.operand2    = operand2_q;
    assign bus.halted      = halted_q;
    assign bus.illegal_op  = illegal_op_q;
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.ins_count   = ins_count_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Random and directed stimulus for micro_sequencer, checked against a plan-based
// model: each fetched instruction expands into its list of microstates.
module tb_micro_sequencer;
    localparam int unsigned T     = 4;
    localparam int unsigned CNT_W = 16;

    localparam logic [8:0] ADD_TR  [6] = '{9'h000, 9'h000, 9'h001, 9'h050, 9'h051, 9'h000};
    localparam logic [8:0] LOAD_TR [9] = '{9'h0E0, 9'h0E6, 9'h0E6, 9'h0E6, 9'h0E6,
                                           9'h1E6, 9'h0E2, 9'h0E3, 9'h000};

    logic clk = 1'b0;
    logic reset;

    micro_sequencer_if #(.CNT_W(CNT_W)) bus ();

    micro_sequencer #(.FETCH_TIMEOUT(T), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [8:0] addr;
        bit         is_wait;
    } item_t;

    item_t       plan[$];
    int          idx;
    int          held;
    bit          halted_m;
    logic [4:0]  exp_opc;
    logic [3:0]  exp_op1, exp_op2;
    logic        exp_halted, exp_illegal, exp_to;
    logic [15:0] exp_count;

    function automatic int n_steps(input logic [4:0] op);
        case (op)
            5'b11010, 5'b01010, 5'b11001, 5'b01011, 5'b00011,
            5'b00101, 5'b00100, 5'b10100, 5'b10101: return 2;
            5'b11011, 5'b11101:                     return 3;
            5'b10001, 5'b10010:                     return 4;
            5'b01101:                               return 1;
            default:                                return 0;
        endcase
    endfunction

    task automatic add(input logic [8:0] a, input bit w);
        item_t it;
        it.addr    = a;
        it.is_wait = w;
        plan.push_back(it);
    endtask

    // Full microstate list of one instruction, starting at FETCH1.
    task automatic build_plan(input logic [4:0] op);
        plan.delete();
        add(9'h000, 1'b1);
        add(9'h001, 1'b0);
        if (op == 5'b11100) begin
            add(9'h0E0, 1'b0); add(9'h0E6, 1'b1); add(9'h1E6, 1'b0);
            add(9'h0E2, 1'b0); add(9'h0E3, 1'b0);
        end else if (op == 5'b10110) begin
            add(9'h0B0, 1'b0); add(9'h0B1, 1'b0);
        end else if (op == 5'b11111) begin
            add(9'h0FF, 1'b0);
        end else begin
            for (int s = 0; s < n_steps(op); s++) add({1'b0, op, 3'(s)}, 1'b0);
        end
    endtask

    task automatic model_reset();
        plan.delete();
        add(9'h000, 1'b1);
        idx = 0; held = 0; halted_m = 0;
        exp_opc = '0; exp_op1 = '0; exp_op2 = '0;
        exp_halted = 0; exp_illegal = 0; exp_to = 0; exp_count = '0;
    endtask

    task automatic advance();
        idx++;
        if (idx >= plan.size()) begin
            plan.delete();
            add(9'h000, 1'b1);
            idx = 0;
        end
        if (plan[idx].is_wait) held = 0;
        if (plan[idx].addr == 9'h0FF) begin
            halted_m   = 1;
            exp_halted = 1;
        end
    endtask

    // Expected effect of one rising edge with the given inputs.
    task automatic model_edge(input logic en, input logic hit, input logic z, input logic [15:0] ins);
        if (halted_m || !en) return;
        exp_to = 0;
        if (plan[idx].is_wait) begin
            if (hit) begin
                if (idx == 0) begin
                    exp_opc = ins[12:8];
                    exp_op1 = ins[7:4];
                    exp_op2 = ins[3:0];
                    build_plan(ins[12:8]);
                end
                advance();
            end else begin
                held++;
                if (held == T) begin
                    exp_to = 1;
                    held   = 0;
                end
            end
        end else begin
            if (idx == 1) begin
                exp_count++;
                if (n_steps(exp_opc) == 0 && exp_opc != 5'b11100 &&
                    exp_opc != 5'b10110 && exp_opc != 5'b11111) exp_illegal = 1;
            end
            if (plan[idx].addr == 9'h0B0) plan[idx+1].addr = z ? 9'h0B1 : 9'h1B1;
            advance();
        end
    endtask

    // Check outputs at the falling edge, then drive the inputs for the next rising edge.
    task automatic cyc(input logic en, input logic hit, input logic z, input logic [15:0] ins);
        @(negedge clk);
        check("addr_ins",    16'(bus.addr_ins),    16'(plan[idx].addr));
        check("operand1",    16'(bus.operand1),    16'(exp_op1));
        check("operand2",    16'(bus.operand2),    16'(exp_op2));
        check("halted",      16'(bus.halted),      16'(exp_halted));
        check("illegal_op",  16'(bus.illegal_op),  16'(exp_illegal));
        check("mem_timeout", 16'(bus.mem_timeout), 16'(exp_to));
        check("ins_count",   16'(bus.ins_count),   exp_count);
        bus.en     = en;
        bus.hit    = hit;
        bus.z_flag = z;
        bus.ins_in = ins;
        model_edge(en, hit, z, ins);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        bus.en = 1'b0;
        reset  = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [4:0] op;
        bus.en = 1'b0; bus.hit = 1'b0; bus.z_flag = 1'b0; bus.ins_in = '0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, i == 1, 1'b0, 16'h0A12);
            check("add_trace", 16'(bus.addr_ins), 16'(ADD_TR[i]));
        end
        check("add_op1",   16'(bus.operand1), 16'd1);
        check("add_op2",   16'(bus.operand2), 16'd2);
        check("add_count", bus.ins_count,     16'd1);

        for (int j = 0; j < 11; j++) begin
            cyc(1'b1, j == 0 || j == 6, 1'b0, 16'h1C34);
            if (j >= 2) check("load_trace", 16'(bus.addr_ins), 16'(LOAD_TR[j-2]));
        end

        for (int zz = 0; zz < 2; zz++) begin
            for (int k = 0; k < 5; k++) begin
                cyc(1'b1, k == 0, zz == 0, 16'h16AB);
                if (k == 2) check("gotoz1", 16'(bus.addr_ins), 16'h0B0);
                if (k == 3) check("gotoz2", 16'(bus.addr_ins), (zz == 0) ? 16'h0B1 : 16'h1B1);
            end
        end

        cyc(1'b1, 1'b1, 1'b0, 16'h0100);
        cyc(1'b1, 1'b0, 1'b0, 16'h0100);
        cyc(1'b1, 1'b0, 1'b0, 16'h0100);
        check("illegal_set",   16'(bus.illegal_op), 16'd1);
        check("illegal_fetch", 16'(bus.addr_ins),   16'h000);
        check("illegal_count", bus.ins_count,       16'd5);

        reset_dut();
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0A12);
            pulses += int'(bus.mem_timeout);
        end
        check("timeout_pulses", 16'(pulses), 16'd2);
        for (int c = 0; c < 4; c++) cyc(1'b1, c == 3, 1'b0, 16'h0A12);
        cyc(1'b1, 1'b0, 1'b0, 16'h0A12);
        check("hit_on_timeout_addr",  16'(bus.addr_ins),    16'h001);
        check("hit_on_timeout_pulse", 16'(bus.mem_timeout), 16'd0);

        for (int n = 0; n < 3000; n++) begin
            op = 5'($urandom);
            if (op == 5'b11111) op = 5'b00000;
            cyc(($urandom % 8) != 0, ($urandom % 3) == 0, 1'($urandom),
                {3'($urandom), op, 8'($urandom)});
        end

        reset_dut();
        cyc(1'b1, 1'b1, 1'b0, 16'h1F00);
        cyc(1'b1, 1'b0, 1'b0, 16'h1F00);
        for (int h = 0; h < 20; h++) begin
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
            check("halt_addr",   16'(bus.addr_ins), 16'h0FF);
            check("halt_halted", 16'(bus.halted),   16'd1);
        end

        @(negedge clk);
        bus.en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_reset_addr",   16'(bus.addr_ins), 16'h000);
        check("async_reset_halted", 16'(bus.halted),   16'd0);
        #1 reset = 1'b0;
        model_reset();
        cyc(1'b1, 1'b1, 1'b0, 16'h0A12);
        cyc(1'b1, 1'b0, 1'b0, 16'h0A12);
        cyc(1'b1, 1'b0, 1'b0, 16'h0A12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
